// File: rtl/cadena_stream.sv
// cadena_stream: streams a stored ASCII message one character per valid/ready transfer.
//   clk, reset             rising-edge clock, synchronous active-high reset
//   start, loop, stop      begin a pass (IDLE only), wrap mode captured at start, abort
//   ready                  downstream accepts dato this cycle
//   valid, dato, idx       current character {zeros, ASCII} and its index
//   busy, done             high while sending; one-cycle pulse after a one-shot pass
module cadena_stream #(
    parameter int MSG_LEN = 32,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              loop,
    input  logic              stop,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] dato,
    output logic [IDX_W-1:0]  idx,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    localparam logic [255:0] MSG = "Hola!...PROYECTO..MICROS........";
    localparam logic [IDX_W-1:0] LAST = IDX_W'(MSG_LEN - 1);
    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
    logic [7:0] chr_q, chr_d;
    logic loop_q, loop_d, last, adv;
    // The string literal packs character 0 at the MSB, so index i lives at byte 31-i.
    function automatic logic [7:0] tbl(input logic [IDX_W-1:0] i);
        logic [31:0] w;
        w = 32'(i);
        return (w >= 32) ? 8'h2E : MSG[{~w[4:0], 3'b000} +: 8];
    endfunction
    always_comb begin
        last    = (idx_q == LAST);
        idx_nxt = last ? '0 : idx_q + IDX_W'(1);
        // The final transfer of a one-shot pass keeps idx on the last character.
        adv     = ready && !(last && !loop_q);
        state_d = state_q;
        idx_d   = idx_q;
        chr_d   = chr_q;
        loop_d  = loop_q;
        if (state_q == IDLE) begin
            if (start && !stop) begin
                state_d = SEND;
                idx_d   = '0;
                chr_d   = tbl('0);
                loop_d  = loop;
            end
        end else if (state_q == SEND) begin
            if (adv) begin
                idx_d = idx_nxt;
                chr_d = tbl(idx_nxt);
            end
            if (stop)
                state_d = IDLE;
            else if (ready && last && !loop_q)
                state_d = DONE;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            chr_q   <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            chr_q   <= chr_d;
            loop_q  <= loop_d;
        end
    end
    assign valid = (state_q == SEND);
    assign busy  = (state_q == SEND);
    assign done  = (state_q == DONE);
    assign dato  = DATA_W'(chr_q);
    assign idx   = idx_q;
endmodule

// File: tb/tb_cadena_stream.sv
// tb_cadena_stream: directed checks of cadena_stream for MSG_LEN 32, 8, 40 and 1.
module tb_cadena_stream;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] start = '0, loop = '0, stop = '0, ready = '0;
    logic [3:0] valid, busy, done;
    logic [3:0][31:0] dato;
    logic [3:0][5:0] idx;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    cadena_stream #(.MSG_LEN(32)) u32 (.clk(clk), .reset(reset), .start(start[0]), .loop(loop[0]),
        .stop(stop[0]), .ready(ready[0]), .valid(valid[0]), .dato(dato[0]), .idx(idx[0]),
        .busy(busy[0]), .done(done[0]));
    cadena_stream #(.MSG_LEN(8)) u8 (.clk(clk), .reset(reset), .start(start[1]), .loop(loop[1]),
        .stop(stop[1]), .ready(ready[1]), .valid(valid[1]), .dato(dato[1]), .idx(idx[1]),
        .busy(busy[1]), .done(done[1]));
    cadena_stream #(.MSG_LEN(40)) u40 (.clk(clk), .reset(reset), .start(start[2]), .loop(loop[2]),
        .stop(stop[2]), .ready(ready[2]), .valid(valid[2]), .dato(dato[2]), .idx(idx[2]),
        .busy(busy[2]), .done(done[2]));
    cadena_stream #(.MSG_LEN(1)) u1 (.clk(clk), .reset(reset), .start(start[3]), .loop(loop[3]),
        .stop(stop[3]), .ready(ready[3]), .valid(valid[3]), .dato(dato[3]), .idx(idx[3]),
        .busy(busy[3]), .done(done[3]));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [7:0] exp_ch(input int i);
        string s;
        s = "Hola!...PROYECTO..MICROS........";
        return (i >= 32) ? 8'h2E : s[i];
    endfunction
    initial begin
        int e, c;
        logic r;
        step();
        step();
        for (int u = 0; u < 4; u++) begin
            chk($sformatf("rst_valid%0d", u), valid[u], 0);
            chk($sformatf("rst_dato%0d", u), dato[u], 0);
            chk($sformatf("rst_idx%0d", u), idx[u], 0);
            chk($sformatf("rst_busy%0d", u), busy[u], 0);
            chk($sformatf("rst_done%0d", u), done[u], 0);
        end
        reset = 1'b0;
        step();
        // one-shot pass, ready tied high
        ready[0] = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("t1_valid%0d", i), valid[0], 1);
            chk($sformatf("t1_idx%0d", i), idx[0], i);
            chk($sformatf("t1_dato%0d", i), dato[0], {24'h0, exp_ch(i)});
            chk($sformatf("t1_done%0d", i), done[0], 0);
            step();
        end
        chk("t1_done_pulse", done[0], 1);
        chk("t1_valid_off", valid[0], 0);
        chk("t1_busy_off", busy[0], 0);
        step();
        chk("t1_done_low", done[0], 0);
        chk("t1_busy_low", busy[0], 0);
        // backpressure, ready pattern 1,0,0,1
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        e = 0;
        c = 0;
        while (e < 32 && c < 200) begin
            chk($sformatf("t2_valid%0d", c), valid[0], 1);
            chk($sformatf("t2_idx%0d", c), idx[0], e);
            chk($sformatf("t2_dato%0d", c), dato[0], {24'h0, exp_ch(e)});
            r = (c % 4 == 0) || (c % 4 == 3);
            ready[0] = r;
            step();
            if (r) e++;
            c++;
        end
        chk("t2_done", done[0], 1);
        chk("t2_count", e, 32);
        ready[0] = 1'b1;
        step();
        // loop mode, MSG_LEN=8, 20 transfers
        ready[1] = 1'b1;
        loop[1] = 1'b1;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        loop[1] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t3_idx%0d", i), idx[1], i % 8);
            chk($sformatf("t3_dato%0d", i), dato[1], {24'h0, exp_ch(i % 8)});
            chk($sformatf("t3_busy%0d", i), busy[1], 1);
            chk($sformatf("t3_done%0d", i), done[1], 0);
            step();
        end
        stop[1] = 1'b1;
        step();
        stop[1] = 1'b0;
        chk("t3_stop_busy", busy[1], 0);
        chk("t3_stop_done", done[1], 0);
        // stop with a simultaneous transfer at idx=5
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (5) step();
        chk("t4_idx5", idx[0], 5);
        chk("t4_dato5", dato[0], 32'h2E);
        stop[0] = 1'b1;
        step();
        stop[0] = 1'b0;
        chk("t4_valid", valid[0], 0);
        chk("t4_busy", busy[0], 0);
        chk("t4_done", done[0], 0);
        chk("t4_idx6", idx[0], 6);
        step();
        chk("t4_done2", done[0], 0);
        chk("t4_idx_hold", idx[0], 6);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk("t4_restart_idx", idx[0], 0);
        chk("t4_restart_dato", dato[0], 32'h48);
        chk("t4_restart_valid", valid[0], 1);
        // reset mid-stream at idx=10, then start while busy
        repeat (10) step();
        chk("t5_idx10", idx[0], 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_valid", valid[0], 0);
        chk("t5_dato", dato[0], 0);
        chk("t5_idx", idx[0], 0);
        chk("t5_busy", busy[0], 0);
        chk("t5_done", done[0], 0);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (3) step();
        chk("t5_idx3", idx[0], 3);
        ready[0] = 1'b0;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk("t5_busy_start_idx", idx[0], 3);
        chk("t5_busy_start_dato", dato[0], 32'h61);
        chk("t5_busy_start_valid", valid[0], 1);
        stop[0] = 1'b1;
        step();
        stop[0] = 1'b0;
        chk("t5_stop_valid", valid[0], 0);
        start[0] = 1'b1;
        stop[0] = 1'b1;
        step();
        start[0] = 1'b0;
        stop[0] = 1'b0;
        chk("t5_start_stop_idle", valid[0], 0);
        chk("t5_start_stop_busy", busy[0], 0);
        // MSG_LEN=40
        ready[2] = 1'b1;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("t6_idx%0d", i), idx[2], i);
            chk($sformatf("t6_dato%0d", i), dato[2], {24'h0, exp_ch(i)});
            step();
        end
        chk("t6_done40", done[2], 1);
        chk("t6_idx_last", idx[2], 39);
        // MSG_LEN=1, two passes
        ready[3] = 1'b1;
        for (int p = 0; p < 2; p++) begin
            start[3] = 1'b1;
            step();
            start[3] = 1'b0;
            chk($sformatf("t6b_valid%0d", p), valid[3], 1);
            chk($sformatf("t6b_dato%0d", p), dato[3], 32'h48);
            chk($sformatf("t6b_idx%0d", p), idx[3], 0);
            step();
            chk($sformatf("t6b_done%0d", p), done[3], 1);
            chk($sformatf("t6b_valid_off%0d", p), valid[3], 0);
            step();
            chk($sformatf("t6b_done_low%0d", p), done[3], 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
